// File: rtl/wormhole_output_allocator_pkg.sv
// -----------------------------------------------------------------------------
// wormhole_output_allocator_pkg
// Shared definitions for the per-output wormhole allocator:
//   - default channel count and downstream credit depth
//   - IDLE/LOCKED state encoding
//   - pairIndex(): maps an upper-triangle matrix coordinate (i<j) onto a
//     flat bit index so only CHANNELS*(CHANNELS-1)/2 priority bits are stored
// -----------------------------------------------------------------------------
package wormhole_output_allocator_pkg;

  localparam int DEF_CHANNELS = 5;
  localparam int DEF_CREDITS  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Row-major packing of the strict upper triangle of an n x n matrix.
  // Caller guarantees i < j.
  function automatic int pairIndex(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/wormhole_output_allocator_lru_matrix_arbiter.sv
// -----------------------------------------------------------------------------
// lru_matrix_arbiter
// Least-recently-served matrix arbiter. Entry W[i][j] (i != j) means input i
// beats input j. Only the upper triangle is stored; W[j][i] for j>i is the
// complement of W[i][j]. On an update strobe the current winner becomes the
// lowest priority input.
// Ports:
//   CLK       clock
//   RST       synchronous active-high reset (input 0 highest priority)
//   cand_i    candidate vector
//   update_i  commit the current grant into the priority matrix
//   grant_o   one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module lru_matrix_arbiter
  import wormhole_output_allocator_pkg::*;
#(
  parameter int N = DEF_CHANNELS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] cand_i,
  input  logic         update_i,
  output logic [N-1:0] grant_o
);

  localparam int PAIRS = (N * (N - 1)) / 2;
  localparam int PW    = (PAIRS > 0) ? PAIRS : 1;

  logic [PW-1:0] upper_q;
  logic [PW-1:0] upper_d;
  logic [N-1:0]  beats [N];
  logic [N-1:0]  blocked;

  // Expand the stored upper triangle into the full beats matrix and compute
  // the post-grant value of every stored bit. A winner in the row clears the
  // bit (winner no longer beats anyone); a winner in the column sets it
  // (everyone now beats the winner).
  for (genvar i = 0; i < N; i++) begin : gRow
    for (genvar j = 0; j < N; j++) begin : gCol
      if (i < j) begin : gUpper
        localparam int P = pairIndex(i, j, N);
        assign beats[i][j] = upper_q[P];
        assign upper_d[P]  = grant_o[j] ? 1'b1 : (grant_o[i] ? 1'b0 : upper_q[P]);
      end else if (i > j) begin : gLower
        localparam int P = pairIndex(j, i, N);
        assign beats[i][j] = ~upper_q[P];
      end else begin : gDiag
        assign beats[i][j] = 1'b0;
      end
    end
  end

  // Input i is blocked when any other candidate j holds priority over it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (cand_i[j] && beats[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end

  assign grant_o = cand_i & ~blocked;

  // Priority bits reset to all ones (upper triangle set), so lower index wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      upper_q <= '1;
    end else if (update_i) begin
      upper_q <= upper_d;
    end
  end

endmodule

// File: rtl/wormhole_output_allocator.sv
// -----------------------------------------------------------------------------
// wormhole_output_allocator
// Shares one router output between CHANNELS inputs at packet granularity.
// Head flits arbitrate through an LRU matrix arbiter; the winner of a
// multi-flit packet holds the port until its tail passes. Every transfer
// consumes one downstream credit.
// Ports:
//   CLK             clock
//   RST             synchronous active-high reset
//   req             input i has a flit waiting for this output
//   head / tail     flit type of input i's waiting flit
//   credit_in       one downstream slot freed (pulse)
//   grant           one-hot/zero, combinational switch grant
//   flit_valid      OR of grant
//   credit_count    current downstream credits
//   busy            port is LOCKED to an owner
//   err_credit_ovf  sticky: credit returned while counter already full
// -----------------------------------------------------------------------------
module wormhole_output_allocator
  import wormhole_output_allocator_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CREDITS  = DEF_CREDITS,
  parameter int CRED_W   = $clog2(CREDITS + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] head,
  input  logic [CHANNELS-1:0] tail,
  input  logic                credit_in,
  output logic [CHANNELS-1:0] grant,
  output logic                flit_valid,
  output logic [CRED_W-1:0]   credit_count,
  output logic                busy,
  output logic                err_credit_ovf
);

  localparam int              OWN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  state_e              state_q, state_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [CRED_W-1:0]   creditCnt_q, creditCnt_d;
  logic                errOvf_q, errOvf_d;
  logic                busy_q;
  logic                creditOk;
  logic                arbUpdate;
  logic [CHANNELS-1:0] arbGrant;
  logic [CHANNELS-1:0] lockGrant;
  logic [OWN_W-1:0]    winnerIdx;

  assign creditOk = (creditCnt_q != '0);

  // The matrix only moves on a real head-flit grant taken in IDLE.
  assign arbUpdate = ~RST & (state_q == IDLE) & creditOk & (|arbGrant);

  lru_matrix_arbiter #(
    .N (CHANNELS)
  ) uArb (
    .CLK      (CLK),
    .RST      (RST),
    .cand_i   (req & head),
    .update_i (arbUpdate),
    .grant_o  (arbGrant)
  );

  // While locked, only the owner may move flits; head is ignored.
  always_comb begin
    lockGrant          = '0;
    lockGrant[owner_q] = req[owner_q] & creditOk;
  end

  // Final grant is forced to zero during reset and without credits.
  always_comb begin
    grant = '0;
    if (!RST) begin
      if (state_q == IDLE) begin
        grant = creditOk ? arbGrant : '0;
      end else begin
        grant = lockGrant;
      end
    end
  end

  assign flit_valid = |grant;

  // Binary encoding of the arbiter winner, used to latch the owner.
  always_comb begin
    winnerIdx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (arbGrant[i]) begin
        winnerIdx = OWN_W'(i);
      end
    end
  end

  // Next-state logic: lock on a granted head without tail, release on a
  // granted tail. Credits follow count - transfer + return, saturating at
  // CREDITS and raising the sticky overflow flag instead of wrapping.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    errOvf_d    = errOvf_q;
    creditCnt_d = creditCnt_q - CRED_W'(flit_valid) + CRED_W'(credit_in);
    case (state_q)
      IDLE: begin
        if (flit_valid && !(|(grant & tail))) begin
          state_d = LOCKED;
          owner_d = winnerIdx;
        end
      end
      LOCKED: begin
        if (flit_valid && tail[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (credit_in && !flit_valid && (creditCnt_q == CRED_MAX)) begin
      creditCnt_d = creditCnt_q;
      errOvf_d    = 1'b1;
    end
  end

  // Single state register block; reset abandons any lock in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      creditCnt_q <= CRED_MAX;
      errOvf_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      creditCnt_q <= creditCnt_d;
      errOvf_q    <= errOvf_d;
      busy_q      <= (state_d == LOCKED);
    end
  end

  assign credit_count   = creditCnt_q;
  assign busy           = busy_q;
  assign err_credit_ovf = errOvf_q;

endmodule
